memory_arbiter: RTL and testbench

//   Shares one synchronous-read memory (1-cycle read latency, en-gated) among

---
 rtl/memory_arbiter.sv | 135 +++++++++++++
 tb/tb_memory_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Shares one synchronous-read memory (1-cycle read latency,
//               enable-gated) among PORTS read requesters. One grant per
//               cycle; the response strobe returns to the winner exactly one
//               cycle after its grant, and read data passes straight through
//               from the memory.
//
//               Optional build macro:
//                 MEMORY_ARBITER_FIXED_PRIORITY_EN
//                   defined   : fixed priority, port 0 highest (no pointer)
//                   undefined : round-robin (default)
//
// Ports       : clk, rst      clock, asynchronous active-high reset
//               req_stb_i     per-port request valid, held until acked
//               req_adr_i     flattened addresses, port i at [i*AW +: AW]
//               req_ack_o     one-hot combinational grant
//               rsp_stb_o     one-hot registered response valid
//               rsp_dat_o     read data, valid while any rsp_stb_o bit is set
//               mem_en_o      memory read enable
//               mem_adr_o     memory address
//               mem_dat_i     memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4096,
    parameter int PORTS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PORTS-1:0]                  req_stb_i,
    input  logic [PORTS*$clog2(DEPTH)-1:0]    req_adr_i,
    output logic [PORTS-1:0]                  req_ack_o,
    output logic [PORTS-1:0]                  rsp_stb_o,
    output logic [WIDTH-1:0]                  rsp_dat_o,
    output logic                              mem_en_o,
    output logic [$clog2(DEPTH)-1:0]          mem_adr_o,
    input  logic [WIDTH-1:0]                  mem_dat_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(PORTS);
    // One extra bit so base+offset can exceed PORTS before wrapping.
    localparam logic [IW:0] c_PORTS = (IW+1)'(PORTS);

    logic [IW-1:0]    w_base;
    logic [IW:0]      w_idx;
    logic             w_found;
    logic [IW-1:0]    w_win;
    logic             w_grant;
    logic [PORTS-1:0] w_ack;
    logic [AW-1:0]    w_adr;
    logic [PORTS-1:0] rsp_stb_q;

`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
    // Scan always starts at port 0.
    assign w_base = '0;
`else
    localparam logic [IW-1:0] c_LAST = IW'(PORTS-1);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    assign w_base = ptr_q;

    // Next base is the port after the winner, wrapping at PORTS-1 rather
    // than at 2**IW-1 so non-power-of-two port counts have no dead slot.
    always_comb begin
        ptr_d = ptr_q;
        if (w_grant) begin
            ptr_d = (w_win == c_LAST) ? '0 : w_win + 1'b1;
        end
    end
`endif

    // Walk offsets from farthest to nearest so the nearest requester to the
    // base overwrites any earlier candidate.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = PORTS-1; k >= 0; k--) begin
            w_idx = {1'b0, w_base} + (IW+1)'(k);
            if (w_idx >= c_PORTS) begin
                w_idx = w_idx - c_PORTS;
            end
            for (int i = 0; i < PORTS; i++) begin
                if ((w_idx == (IW+1)'(i)) && req_stb_i[i]) begin
                    w_found = 1'b1;
                    w_win   = IW'(i);
                end
            end
        end
    end

    // No grant may leave the block while reset is held.
    assign w_grant = w_found & ~rst;

    always_comb begin
        w_ack = '0;
        w_adr = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (w_grant && (w_win == IW'(i))) begin
                w_ack[i] = 1'b1;
                w_adr    = req_adr_i[i*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_stb_q <= '0;
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
            ptr_q     <= '0;
`endif
        end else begin
            rsp_stb_q <= w_ack;
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign req_ack_o = w_ack;
    assign mem_en_o  = w_grant;
    assign mem_adr_o = w_adr;
    assign rsp_stb_o = rsp_stb_q;
    // Memory registers its own output, so data lines up with rsp_stb_q.
    assign rsp_dat_o = mem_dat_i;

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter. A 4-port and a 3-port
//               instance share one behavioural memory image; a reference model
//               written from the arbitration rules predicts grants, addresses,
//               response strobes and response data every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-port instance
    logic [3:0]      req4 = '0;
    logic [4*AW-1:0] adr4 = '0;
    logic [3:0]      ack4, rsp4;
    logic [WIDTH-1:0] dat4, mdat4;
    logic            en4;
    logic [AW-1:0]   madr4;

    // 3-port instance
    logic [2:0]      req3 = '0;
    logic [3*AW-1:0] adr3 = '0;
    logic [2:0]      ack3, rsp3;
    logic [WIDTH-1:0] dat3, mdat3;
    logic            en3;
    logic [AW-1:0]   madr3;

    memory_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_stb_i(req4), .req_adr_i(adr4),
        .req_ack_o(ack4), .rsp_stb_o(rsp4), .rsp_dat_o(dat4),
        .mem_en_o(en4), .mem_adr_o(madr4), .mem_dat_i(mdat4)
    );

    memory_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_stb_i(req3), .req_adr_i(adr3),
        .req_ack_o(ack3), .rsp_stb_o(rsp3), .rsp_dat_o(dat3),
        .mem_en_o(en3), .mem_adr_o(madr3), .mem_dat_i(mdat3)
    );

    // Behavioural synchronous-read memories with a shared image
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (en4) mdat4 <= mem[madr4];
        if (en3) mdat3 <= mem[madr3];
    end

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    function automatic int winner(input logic [3:0] req, input int ptr, input int ports);
        int base;
        base = ptr;
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
        base = 0;
`endif
        for (int k = 0; k < ports; k++) begin
            int p;
            p = (base + k) % ports;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int w);
        if (w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    function automatic logic [AW-1:0] adr_of(input logic [4*AW-1:0] a, input int w);
        if (w < 0) return '0;
        return a[w*AW +: AW];
    endfunction

    int              m_ptr4 = 0, m_ptr3 = 0;
    logic [3:0]      m_rsp4 = '0;
    logic [2:0]      m_rsp3 = '0;
    logic [WIDTH-1:0] m_dat4 = '0, m_dat3 = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr4 <= 0;
            m_ptr3 <= 0;
            m_rsp4 <= '0;
            m_rsp3 <= '0;
        end else begin
            m_rsp4 <= onehot(winner(req4, m_ptr4, 4));
            if (winner(req4, m_ptr4, 4) >= 0) begin
                m_dat4 <= mem[adr_of(adr4, winner(req4, m_ptr4, 4))];
                m_ptr4 <= (winner(req4, m_ptr4, 4) + 1) % 4;
            end
            m_rsp3 <= 3'(onehot(winner({1'b0, req3}, m_ptr3, 3)));
            if (winner({1'b0, req3}, m_ptr3, 3) >= 0) begin
                m_dat3 <= mem[adr_of({AW'(0), adr3}, winner({1'b0, req3}, m_ptr3, 3))];
                m_ptr3 <= (winner({1'b0, req3}, m_ptr3, 3) + 1) % 3;
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst  = 1'b1;
        req4 = '0;
        req3 = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst  = 1'b1;
        req4 = 4'b1111;
        req3 = 3'b111;
        adr4 = {12'h333, 12'h222, 12'h111, 12'h000};
        adr3 = {12'h777, 12'h666, 12'h555};
        @(negedge clk);
        checks++;
        if ({ack4, en4, madr4, rsp4} !== '0) begin
            errors++;
            $display("FAIL reset4: ack=%b en=%b adr=%h rsp=%b, expected all zero", ack4, en4, madr4, rsp4);
        end
        checks++;
        if ({ack3, en3, madr3, rsp3} !== '0) begin
            errors++;
            $display("FAIL reset3: ack=%b en=%b adr=%h rsp=%b, expected all zero", ack3, en3, madr3, rsp3);
        end
        next_cycle();
        req4 = '0;
        req3 = '0;
        rst  = 1'b0;
        next_cycle();
    endtask

    task automatic test_single;
        req4 = 4'b0100;
        adr4 = '0;
        adr4[2*AW +: AW] = 12'h123;
        @(negedge clk);
        checks++;
        if (ack4 !== 4'b0100 || en4 !== 1'b1 || madr4 !== 12'h123) begin
            errors++;
            $display("FAIL single_grant: ack=%b en=%b adr=%h, expected 0100 1 123", ack4, en4, madr4);
        end
        next_cycle();
        req4 = '0;
        @(negedge clk);
        checks++;
        if (rsp4 !== 4'b0100 || dat4 !== mem[12'h123]) begin
            errors++;
            $display("FAIL single_rsp: rsp=%b dat=%h, expected 0100 %h", rsp4, dat4, mem[12'h123]);
        end
        checks++;
        if (ack4 !== 4'b0000 || en4 !== 1'b0 || madr4 !== '0) begin
            errors++;
            $display("FAIL idle: ack=%b en=%b adr=%h, expected 0000 0 000", ack4, en4, madr4);
        end
        next_cycle();
    endtask

    task automatic test_round_robin;
        int exp_w;
        int prev_w;
        do_reset();
        req4 = 4'b1111;
        adr4 = {12'd3, 12'd2, 12'd1, 12'd0};
        prev_w = -1;
        for (int n = 0; n < 6; n++) begin
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
            exp_w = 0;
`else
            exp_w = n % 4;
`endif
            @(negedge clk);
            checks++;
            if (ack4 !== onehot(exp_w) || madr4 !== AW'(exp_w) || en4 !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant[%0d]: ack=%b adr=%h, expected %b %h", n, ack4, madr4, onehot(exp_w), AW'(exp_w));
            end
            checks++;
            if (rsp4 !== onehot(prev_w) || (prev_w >= 0 && dat4 !== mem[AW'(prev_w)])) begin
                errors++;
                $display("FAIL rr_rsp[%0d]: rsp=%b dat=%h, expected %b", n, rsp4, dat4, onehot(prev_w));
            end
            prev_w = exp_w;
            next_cycle();
        end
        req4 = '0;
    endtask

    task automatic test_wrap3;
        int seq [3];
        do_reset();
        // Port 1 alone wins once, leaving the base at port 2.
        req3 = 3'b010;
        adr3 = {12'hC02, 12'hC01, 12'hC00};
        next_cycle();
        req3 = 3'b101;
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
        seq = '{0, 0, 0};
`else
        seq = '{2, 0, 2};
`endif
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (ack3 !== 3'(onehot(seq[n])) || madr3 !== (12'hC00 + AW'(seq[n]))) begin
                errors++;
                $display("FAIL wrap3[%0d]: ack=%b adr=%h, expected %b %h", n, ack3, madr3, 3'(onehot(seq[n])), 12'hC00 + AW'(seq[n]));
            end
            next_cycle();
        end
        req3 = '0;
        @(negedge clk);
        checks++;
        if (rsp3 !== 3'(onehot(seq[2])) || dat3 !== mem[12'hC00 + AW'(seq[2])]) begin
            errors++;
            $display("FAIL wrap3_rsp: rsp=%b dat=%h, expected %b", rsp3, dat3, 3'(onehot(seq[2])));
        end
        next_cycle();
    endtask

    task automatic test_mid_reset;
        do_reset();
        req4 = 4'b0010;
        adr4 = {12'h0D3, 12'h0D2, 12'h0D1, 12'h0D0};
        @(negedge clk);
        checks++;
        if (ack4 !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_grant: ack=%b, expected 0010", ack4);
        end
        #2 rst = 1'b1;
        next_cycle();
        req4 = 4'b1111;
        @(negedge clk);
        checks++;
        if (rsp4 !== 4'b0000 || ack4 !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_rsp: rsp=%b ack=%b, expected 0000 0000", rsp4, ack4);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ack4 !== 4'b0001 || madr4 !== 12'h0D0) begin
            errors++;
            $display("FAIL midrst_first: ack=%b adr=%h, expected 0001 0D0", ack4, madr4);
        end
        next_cycle();
        req4 = '0;
        next_cycle();
    endtask

    task automatic test_sparse_pair;
        // Ports 1 and 3 held: round-robin alternates, fixed priority starves 3.
        do_reset();
        req4 = 4'b1010;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
            if (ack4 !== 4'b0010) begin
                errors++;
                $display("FAIL pair[%0d]: ack=%b, expected 0010", n, ack4);
            end
`else
            if (ack4 !== ((n % 2 == 0) ? 4'b0010 : 4'b1000)) begin
                errors++;
                $display("FAIL pair[%0d]: ack=%b, expected %b", n, ack4, (n % 2 == 0) ? 4'b0010 : 4'b1000);
            end
`endif
            next_cycle();
        end
        req4 = '0;
    endtask

    task automatic test_random;
        int w4, w3;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req4 = 4'($urandom_range(0, 15));
            req3 = 3'($urandom_range(0, 7));
            adr4 = {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
            adr3 = {12'($urandom), 12'($urandom), 12'($urandom)};
            @(negedge clk);
            w4 = winner(req4, m_ptr4, 4);
            w3 = winner({1'b0, req3}, m_ptr3, 3);
            checks++;
            if (ack4 !== onehot(w4) || en4 !== (w4 >= 0) || madr4 !== adr_of(adr4, w4)) begin
                errors++;
                $display("FAIL rand4_grant[%0d]: ack=%b en=%b adr=%h, expected %b %b %h", n, ack4, en4, madr4, onehot(w4), w4 >= 0, adr_of(adr4, w4));
            end
            checks++;
            if (rsp4 !== m_rsp4 || (m_rsp4 != 0 && dat4 !== m_dat4)) begin
                errors++;
                $display("FAIL rand4_rsp[%0d]: rsp=%b dat=%h, expected %b %h", n, rsp4, dat4, m_rsp4, m_dat4);
            end
            checks++;
            if (ack3 !== 3'(onehot(w3)) || en3 !== (w3 >= 0) || madr3 !== adr_of({AW'(0), adr3}, w3)) begin
                errors++;
                $display("FAIL rand3_grant[%0d]: ack=%b en=%b adr=%h, expected %b %b %h", n, ack3, en3, madr3, 3'(onehot(w3)), w3 >= 0, adr_of({AW'(0), adr3}, w3));
            end
            checks++;
            if (rsp3 !== m_rsp3 || (m_rsp3 != 0 && dat3 !== m_dat3)) begin
                errors++;
                $display("FAIL rand3_rsp[%0d]: rsp=%b dat=%h, expected %b %h", n, rsp3, dat3, m_rsp3, m_dat3);
            end
            next_cycle();
        end
        req4 = '0;
        req3 = '0;
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) mem[a] = WIDTH'($urandom);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap3();
        test_mid_reset();
        test_sparse_pair();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
